pipe_hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the rooth RV32 core; sits beside the ID-stage operand forwarding unit.
- Decides every cycle whether PC, IF/ID and ID/EX advance, hold or flush.
- Covers four cases: load-use hazards the forwarding path cannot resolve, multi-cycle divide occupancy of EX, interrupt entry hold, and jump/branch redirect.
- Forwarding supplies data; this block supplies the stalls and bubbles that make the forwarded data valid.

---
 rtl/pipe_hazard_ctrl.sv | 72 +++++++
 tb/tb_pipe_hazard_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: PC / IF/ID / ID/EX hold and flush sequencing for load-use, divide, interrupt and jump.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CPU_WIDTH      = 32,
    parameter int DIV_CYCLES     = 33
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_adder_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_adder_i,
    input  logic                      ex_mem_rd_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_reg_wr_adder_i,
    input  logic                      ex_div_req_i,
    input  logic                      jump_req_i,
    input  logic [CPU_WIDTH-1:0]      jump_adder_i,
    input  logic                      int_req_i,
    input  logic                      int_done_i,
    output logic                      hold_pc_o,
    output logic                      hold_if_id_o,
    output logic                      flush_if_id_o,
    output logic                      flush_id_ex_o,
    output logic                      hold_ex_o,
    output logic                      jump_en_o,
    output logic [CPU_WIDTH-1:0]      jump_adder_o,
    output logic                      div_busy_o
);
    typedef enum logic [1:0] {IDLE, DIV_BUSY, INT_HOLD} state_t;
    state_t     state, state_nxt;
    logic [5:0] cnt, cnt_nxt;
    logic       load_use, stall, busy, ih;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    assign load_use = ex_mem_rd_i && |ex_reg_wr_adder_i &&
                      (id_rs1_adder_i == ex_reg_wr_adder_i || id_rs2_adder_i == ex_reg_wr_adder_i);
    assign stall = state == IDLE && !int_req_i && !ex_div_req_i && load_use;
    // the last DIV_BUSY cycle (cnt==0) releases every hold so the divide result commits
    assign busy  = state == DIV_BUSY && cnt != '0;
    assign ih    = state == INT_HOLD;
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (jump_req_i) begin
            state_nxt = (ih && !int_done_i) ? INT_HOLD : IDLE;
            cnt_nxt   = '0;
        end else if (state == IDLE) begin
            state_nxt = int_req_i ? INT_HOLD : ex_div_req_i ? DIV_BUSY : IDLE;
            cnt_nxt   = (!int_req_i && ex_div_req_i) ? 6'(DIV_CYCLES - 1) : cnt;
        end else if (state == DIV_BUSY) begin
            state_nxt = cnt == '0 ? IDLE : DIV_BUSY;
            cnt_nxt   = cnt == '0 ? cnt : cnt - 6'd1;
        end else begin
            state_nxt = int_done_i ? IDLE : INT_HOLD;
        end
    end
    // outputs are forced low while reset is asserted, even though they are combinational
    always_comb begin
        hold_pc_o     = rst_n && !jump_req_i && (stall || busy || ih);
        hold_if_id_o  = hold_pc_o;
        flush_if_id_o = rst_n && jump_req_i;
        flush_id_ex_o = rst_n && (jump_req_i || stall || ih);
        hold_ex_o     = rst_n && !jump_req_i && busy;
        jump_en_o     = rst_n && jump_req_i;
        jump_adder_o  = jump_en_o ? jump_adder_i : '0;
        div_busy_o    = rst_n && busy;
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed stimulus with a cycle-level behavioural model and literal spot checks.
module tb_pipe_hazard_ctrl;
    localparam int DC = 33;
    logic        clk = 0, rst_n = 0;
    logic [4:0]  rs1 = 0, rs2 = 0, rd = 0;
    logic        mem_rd = 0, div_req = 0, jump = 0, int_req = 0, int_done = 0;
    logic [31:0] jadr = 0, jadr_o;
    logic        hold_pc, hold_if_id, flush_if_id, flush_id_ex, hold_ex, jump_en, div_busy;
    int          checks = 0, errors = 0;
    bit          run = 0;
    int          phase = 0;
    bit          in_int = 0;

    pipe_hazard_ctrl #(.REG_ADDR_WIDTH(5), .CPU_WIDTH(32), .DIV_CYCLES(DC)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_adder_i(rs1), .id_rs2_adder_i(rs2),
        .ex_mem_rd_i(mem_rd), .ex_reg_wr_adder_i(rd),
        .ex_div_req_i(div_req), .jump_req_i(jump), .jump_adder_i(jadr),
        .int_req_i(int_req), .int_done_i(int_done),
        .hold_pc_o(hold_pc), .hold_if_id_o(hold_if_id), .flush_if_id_o(flush_if_id),
        .flush_id_ex_o(flush_id_ex), .hold_ex_o(hold_ex), .jump_en_o(jump_en),
        .jump_adder_o(jadr_o), .div_busy_o(div_busy)
    );

    always #5 clk = ~clk;

    wire [6:0] outs = {hold_pc, hold_if_id, flush_if_id, flush_id_ex, hold_ex, jump_en, div_busy};

    // phase = cycles left until the divide sequence is back in IDLE; the final one releases EX
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            phase  <= 0;
            in_int <= 0;
        end else if (jump) begin
            phase  <= 0;
            in_int <= in_int && !int_done;
        end else if (phase == 0 && !in_int) begin
            if (int_req) in_int <= 1;
            else if (div_req) phase <= DC;
        end else if (phase > 0) phase <= phase - 1;
        else if (int_done) in_int <= 0;

    function automatic logic [38:0] expect_now();
        bit idle, busy, lu, hp;
        idle = phase == 0 && !in_int;
        busy = phase > 1;
        lu   = idle && !int_req && !div_req && mem_rd && rd != 0 && (rs1 == rd || rs2 == rd);
        hp   = !jump && (lu || busy || in_int);
        if (!rst_n) return '0;
        return {hp, hp, jump, jump || lu || in_int, !jump && busy, jump, busy, jump ? jadr : 32'h0};
    endfunction

    task automatic chk(input string n, input logic [38:0] got, input logic [38:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", n, got, exp, $time);
        end
    endtask

    always @(negedge clk) if (run) chk("model", {outs, jadr_o}, expect_now());

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic clr();
        rs1 = 0; rs2 = 0; rd = 0; mem_rd = 0; div_req = 0;
        jump = 0; jadr = 0; int_req = 0; int_done = 0;
    endtask
    task automatic lit(input string n, input logic [6:0] exp, input logic [31:0] adr = 0);
        #1 chk(n, {outs, jadr_o}, {exp, adr});
    endtask

    localparam logic [6:0] STALL = 7'b1101000, BUSY = 7'b1100101, IHOLD = 7'b1101000;

    initial begin
        #3 lit("reset_outs", 7'b0);
        run = 1;
        repeat (2) tick();
        rst_n = 1;
        tick();
        lit("idle_after_reset", 7'b0);
        mem_rd = 1; rd = 5; rs2 = 5;
        lit("load_use_rs2", STALL);
        tick(); clr();
        lit("load_use_one_cycle", 7'b0);
        mem_rd = 1; rd = 0; rs2 = 0;
        lit("load_use_rd0", 7'b0);
        tick(); clr();
        mem_rd = 1; rd = 7; rs1 = 7;
        lit("load_use_rs1", STALL);
        tick(); clr();
        mem_rd = 1; rd = 5; rs2 = 5; jump = 1; jadr = 32'h8000_0040;
        lit("jump_over_load_use", 7'b0011010, 32'h8000_0040);
        tick(); clr();
        div_req = 1;
        lit("div_accept", 7'b0);
        tick(); clr();
        for (int i = 0; i < DC - 1; i++) begin
            if (i == 0 || i == DC - 2) lit("div_busy", BUSY);
            tick();
        end
        mem_rd = 1; rd = 3; rs1 = 3;
        lit("div_final_release", 7'b0);
        tick();
        lit("load_use_after_div", STALL);
        tick(); clr();
        int_req = 1;
        lit("int_accept", 7'b0);
        tick();
        for (int i = 0; i < 3; i++) begin lit("int_hold", IHOLD); tick(); end
        int_req = 0; int_done = 1;
        lit("int_done_cycle", IHOLD);
        tick(); clr();
        lit("int_exit", 7'b0);
        div_req = 1;
        tick(); clr();
        int_req = 1;
        repeat (DC - 1) tick();
        lit("int_deferred_final", 7'b0);
        tick();
        lit("int_after_div_accept", 7'b0);
        tick();
        lit("int_after_div_hold", IHOLD);
        int_req = 0; int_done = 1;
        tick(); clr();
        div_req = 1;
        tick(); clr();
        repeat (12) tick();
        jump = 1; jadr = 32'h0000_0100;
        lit("div_abort", 7'b0011011, 32'h0000_0100);
        tick(); clr();
        lit("div_abort_idle", 7'b0);
        int_req = 1;
        tick();
        jump = 1; jadr = 32'h0000_0200; int_done = 1; int_req = 0;
        lit("jump_int_done", 7'b0011010, 32'h0000_0200);
        tick(); clr();
        lit("jump_int_idle", 7'b0);
        div_req = 1;
        tick(); clr();
        repeat (20) tick();
        lit("pre_reset_busy", BUSY);
        mem_rd = 1; rd = 9; rs2 = 9;
        rst_n = 0;
        lit("async_reset_outs", 7'b0);
        tick();
        rst_n = 1;
        tick();
        lit("post_reset_stall", STALL);
        tick(); clr();
        lit("post_reset_idle", 7'b0);
        tick();
        run = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end
endmodule
